ram_cmd_arbiter: RTL and testbench

//  Shares the single-port 256x8 command RAM between two requesters (req port 0, req port 1).

---
 rtl/ram_cmd_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/ram_cmd_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_cmd_pkg.sv
// Shared op codes, FSM state encoding and default widths for the RAM command arbiter.
package ram_cmd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD_ADDR = 3'd1,
        ST_CMD_DATA = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the port that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       en,
    output logic [1:0] gnt
);

    // Combinational grant selection
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two requesters onto the single-port command RAM and sequences its commands.
// Optional RAM_ADDR_CACHE_EN skips the address command when the RAM already holds that address.
module ram_cmd_arbiter
    import ram_cmd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [DATA_W+1:0] ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    state_e              state_r, state_nxt_s;
    logic                gnt_port_r, we_r, last_gnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r, rdata_r, rdata_nxt_s;
    logic [TW-1:0]       cnt_r, cnt_nxt_s;
    logic                ack0_r, ack1_r, err_r, busy_r, rxv_r;
    logic                ack0_nxt_s, ack1_nxt_s, err_nxt_s, rxv_nxt_s;
    logic [DATA_W+1:0]   din_r, din_nxt_s;
    logic [1:0]          gnt_s;
    logic                grant_s, sel_we_s, skip_s, timeout_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    function automatic logic [DATA_W+1:0] data_cmd(input logic we, input logic [DATA_W-1:0] wd);
        return we ? {OP_WR_DATA, wd} : {OP_RD_DATA, {DATA_W{1'b0}}};
    endfunction

    rr_arb2 u_arb (
        .req      ({req1, req0}),
        .last_gnt (last_gnt_r),
        .en       (state_r == ST_IDLE),
        .gnt      (gnt_s)
    );

    assign grant_s     = |gnt_s;
    assign sel_we_s    = gnt_s[1] ? we1 : we0;
    assign sel_addr_s  = gnt_s[1] ? addr1 : addr0;
    assign sel_wdata_s = gnt_s[1] ? wdata1 : wdata0;
    assign timeout_s   = (state_r == ST_RD_WAIT) && !ram_tx_valid
                         && (cnt_r == TW'(RD_TIMEOUT - 1));

`ifdef RAM_ADDR_CACHE_EN
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic              wr_vld_q, rd_vld_q;

    assign skip_s = sel_we_s ? (wr_vld_q && (wr_addr_q == sel_addr_s))
                             : (rd_vld_q && (rd_addr_q == sel_addr_s));

    // Shadow of the RAM's internal write/read address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= {ADDR_W{1'b0}};
            rd_addr_q <= {ADDR_W{1'b0}};
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else if (timeout_s) begin
            wr_vld_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else if ((state_r == ST_IDLE) && grant_s && !skip_s) begin
            if (sel_we_s) begin
                wr_addr_q <= sel_addr_s;
                wr_vld_q  <= 1'b1;
            end else begin
                rd_addr_q <= sel_addr_s;
                rd_vld_q  <= 1'b1;
            end
        end else begin
            wr_vld_q  <= wr_vld_q;
            rd_vld_q  <= rd_vld_q;
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    // Next state plus the registered output values belonging to that state
    always_comb begin
        state_nxt_s = state_r;
        din_nxt_s   = {(DATA_W + 2){1'b0}};
        rxv_nxt_s   = 1'b0;
        ack0_nxt_s  = 1'b0;
        ack1_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        rdata_nxt_s = rdata_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    rxv_nxt_s = 1'b1;
                    if (skip_s) begin
                        state_nxt_s = ST_CMD_DATA;
                        din_nxt_s   = data_cmd(sel_we_s, sel_wdata_s);
                    end else begin
                        state_nxt_s = ST_CMD_ADDR;
                        din_nxt_s   = {sel_we_s ? OP_WR_ADDR : OP_RD_ADDR, sel_addr_s};
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CMD_ADDR: begin
                state_nxt_s = ST_CMD_DATA;
                din_nxt_s   = data_cmd(we_r, wdata_r);
                rxv_nxt_s   = 1'b1;
            end
            ST_CMD_DATA: begin
                if (we_r) begin
                    state_nxt_s = ST_ACK;
                    ack0_nxt_s  = ~gnt_port_r;
                    ack1_nxt_s  = gnt_port_r;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                    cnt_nxt_s   = {TW{1'b0}};
                end
            end
            ST_RD_WAIT: begin
                if (ram_tx_valid) begin
                    state_nxt_s = ST_ACK;
                    ack0_nxt_s  = ~gnt_port_r;
                    ack1_nxt_s  = gnt_port_r;
                    rdata_nxt_s = ram_dout;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ACK;
                    ack0_nxt_s  = ~gnt_port_r;
                    ack1_nxt_s  = gnt_port_r;
                    err_nxt_s   = 1'b1;
                    rdata_nxt_s = {DATA_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + TW'(1);
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, transaction latches and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_port_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            last_gnt_r <= 1'b1;
            cnt_r      <= {TW{1'b0}};
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            rxv_r      <= 1'b0;
            din_r      <= {(DATA_W + 2){1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ack0_r  <= ack0_nxt_s;
            ack1_r  <= ack1_nxt_s;
            err_r   <= err_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            rxv_r   <= rxv_nxt_s;
            din_r   <= din_nxt_s;
            rdata_r <= rdata_nxt_s;
            if ((state_r == ST_IDLE) && grant_s) begin
                gnt_port_r <= gnt_s[1];
                we_r       <= sel_we_s;
                addr_r     <= sel_addr_s;
                wdata_r    <= sel_wdata_s;
            end else begin
                gnt_port_r <= gnt_port_r;
                we_r       <= we_r;
                addr_r     <= addr_r;
                wdata_r    <= wdata_r;
            end
            if (state_r == ST_ACK) begin
                last_gnt_r <= gnt_port_r;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end
    end

    assign ack0         = ack0_r;
    assign ack1         = ack1_r;
    assign err          = err_r;
    assign busy         = busy_r;
    assign rdata        = rdata_r;
    assign ram_din      = din_r;
    assign ram_rx_valid = rxv_r;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed self-checking bench for ram_cmd_arbiter with a behavioural 256x8 command RAM.
// Expectations follow RAM_ADDR_CACHE_EN when it is defined for the build.
module tb_ram_cmd_arbiter;

`ifdef RAM_ADDR_CACHE_EN
    localparam logic CACHE_EN = 1'b1;
`else
    localparam logic CACHE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, err, busy, ram_rx_valid, ram_tx_valid;
    logic [7:0] rdata, ram_dout;
    logic [9:0] ram_din;
    logic       ram_mute;

    int errors_cnt = 0;
    int checks_cnt = 0;

    // Expected RAM address registers as seen by the cache (bench's own model)
    logic [7:0] sh_wa, sh_ra;
    logic       sh_wv, sh_rv;

    logic [7:0] mem [0:255];
    logic [7:0] m_wa, m_ra;

    always #5 clk = ~clk;

    ram_cmd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
    );

    // Command RAM: one-cycle read latency, read response suppressible
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_tx_valid <= 1'b0;
            ram_dout     <= 8'h00;
        end else begin
            ram_tx_valid <= 1'b0;
            if (ram_rx_valid) begin
                case (ram_din[9:8])
                    2'b00: m_wa <= ram_din[7:0];
                    2'b01: mem[m_wa] <= ram_din[7:0];
                    2'b10: m_ra <= ram_din[7:0];
                    default: begin
                        ram_tx_valid <= !ram_mute;
                        ram_dout     <= mem[m_ra];
                    end
                endcase
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_shadow();
        sh_wv = 1'b0;
        sh_rv = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_shadow();
    endtask

    task automatic drive_port(input int p, input logic rq, input logic we,
                              input logic [7:0] addr, input logic [7:0] wdata);
        if (p == 0) begin
            req0 = rq; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = rq; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    // One full transaction on port p, checked cycle by cycle
    task automatic run_txn(input int p, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic mute,
                           input logic [7:0] exp_rdata, input logic exp_err);
        logic skip;
        int   waits;
        skip = CACHE_EN && (we ? (sh_wv && sh_wa == addr) : (sh_rv && sh_ra == addr));
        @(negedge clk);
        ram_mute = mute;
        drive_port(p, 1'b1, we, addr, wdata);
        if (!skip) begin
            @(negedge clk);
            check_eq("cmd_addr", ram_din, {(we ? 2'b00 : 2'b10), addr});
            check_eq("addr_strobe", ram_rx_valid, 1'b1);
            if (we) begin
                sh_wa = addr; sh_wv = 1'b1;
            end else begin
                sh_ra = addr; sh_rv = 1'b1;
            end
        end
        @(negedge clk);
        check_eq("cmd_data", ram_din, we ? {2'b01, wdata} : {2'b11, 8'h00});
        check_eq("data_strobe", ram_rx_valid, 1'b1);
        if (!we) begin
            waits = mute ? 4 : 1;
            for (int i = 0; i < waits; i++) begin
                @(negedge clk);
                check_eq("rd_wait_ack", {ack1, ack0}, 2'b00);
                check_eq("rd_wait_strobe", ram_rx_valid, 1'b0);
            end
        end
        @(negedge clk);
        check_eq("ack_own", (p == 0) ? ack0 : ack1, 1'b1);
        check_eq("ack_other", (p == 0) ? ack1 : ack0, 1'b0);
        check_eq("err", err, exp_err);
        if (!we) check_eq("rdata", rdata, exp_rdata);
        drive_port(p, 1'b0, we, addr, wdata);
        ram_mute = 1'b0;
        if (exp_err) clear_shadow();
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_ack", {ack1, ack0}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ram_mute = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        clear_shadow();
        sh_wa = 8'h00; sh_ra = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_ack", {ack1, ack0}, 2'b00);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rxv", ram_rx_valid, 1'b0);
        check_eq("rst_din", ram_din, 10'h000);
        check_eq("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;

        // Write then read back through the other port
        run_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00, 1'b0);
        run_txn(1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5, 1'b0);

        // Simultaneous held requests after reset: grants 0,1,0
        @(negedge clk);
        do_reset();
        drive_port(0, 1'b1, 1'b1, 8'h01, 8'h11);
        drive_port(1, 1'b1, 1'b1, 8'h02, 8'h22);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check_eq("rr_ack0", ack0, (c == 3) || (c == 11));
            check_eq("rr_ack1", ack1, (c == 7));
            if (c == 5) check_eq("rr_din_p1", ram_din, 10'h002);
            if (c == 9) check_eq("rr_din_p0", ram_din, 10'h001);
            if (c == 11) begin
                drive_port(0, 1'b0, 1'b1, 8'h01, 8'h11);
                drive_port(1, 1'b0, 1'b1, 8'h02, 8'h22);
            end
        end
        @(negedge clk);
        check_eq("rr_idle", busy, 1'b0);
        sh_wa = 8'h01; sh_wv = 1'b1;

        // Read timeout
        run_txn(0, 1'b0, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1);

        // Async reset during CMD_DATA
        @(negedge clk);
        drive_port(1, 1'b1, 1'b1, 8'h55, 8'h77);
        @(negedge clk);
        check_eq("rst_mid_addr", ram_din, 10'h055);
        @(negedge clk);
        check_eq("rst_mid_data", ram_din, 10'h177);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_rxv", ram_rx_valid, 1'b0);
        check_eq("rst_mid_din", ram_din, 10'h000);
        check_eq("rst_mid_busy", busy, 1'b0);
        drive_port(1, 1'b0, 1'b1, 8'h55, 8'h77);
        @(negedge clk);
        check_eq("rst_mid_ack", {ack1, ack0}, 2'b00);
        rst_n = 1'b1;
        clear_shadow();
        run_txn(1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5, 1'b0);

        // Repeated addresses (address command skipped when caching)
        run_txn(0, 1'b1, 8'h10, 8'h5A, 1'b0, 8'h00, 1'b0);
        run_txn(0, 1'b1, 8'h10, 8'hC3, 1'b0, 8'h00, 1'b0);
        run_txn(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hC3, 1'b0);
        run_txn(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hC3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
